// File: rtl/servo_pwm.sv
// Servo PWM generator: frame counter with pending/active position registers
// and a one-cycle end-of-frame strobe. Define SERVO_LIMITE_EN to clamp positions to POS_MAX.
module servo_pwm #(
  parameter int PERIODO     = 1000000,
  parameter int LARGURA_MIN = 50000,
  parameter int PASSO       = 7143,
  parameter int NPOS        = 3,
  parameter int POS_MAX     = 7
) (
  input  logic            clock,
  input  logic            zera_as_n,
  input  logic            liga,
  input  logic            carrega,
  input  logic [NPOS-1:0] posicao,
  output logic            pwm,
  output logic            fim_periodo,
  output logic [NPOS-1:0] posicao_atual
);

  localparam int     CW        = $clog2(PERIODO);
  localparam longint LARG_MAX  = longint'(LARGURA_MIN) + longint'((1 << NPOS) - 1) * longint'(PASSO);
  localparam int     WW        = $clog2(LARG_MAX + 1);
  localparam int     MW        = (WW > CW) ? WW : CW;
  localparam logic [CW-1:0] CNT_ULT = CW'(PERIODO - 1);

  function automatic logic [NPOS-1:0] limita_pos(input logic [NPOS-1:0] p);
`ifdef SERVO_LIMITE_EN
    return (int'(p) > POS_MAX) ? NPOS'(POS_MAX) : p;
`else
    return p;
`endif
  endfunction

  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rodando_q, rodando_d;
  logic [NPOS-1:0] pendente_q, pendente_d;
  logic [NPOS-1:0] ativo_q, ativo_d;
  logic            pwm_q, pwm_d;
  logic            fim_q, fim_d;
  logic [NPOS-1:0] pos_in;
  logic            fronteira;
  logic [MW-1:0]   largura_d;

  always_comb begin
    pos_in     = limita_pos(posicao);
    pendente_d = carrega ? pos_in : pendente_q;
    rodando_d  = liga;
    cnt_d      = '0;
    // Restarting after liga=0 counts as a frame boundary, so active is refreshed then too
    fronteira  = !liga || !rodando_q || (cnt_q == CNT_ULT);
    ativo_d    = fronteira ? pendente_d : ativo_q;

    if (liga && rodando_q && (cnt_q != CNT_ULT)) begin
      cnt_d = cnt_q + CW'(1);
    end

    // Outputs are registered from next-state values so they line up with cnt_q
    largura_d = MW'(LARGURA_MIN) + MW'(ativo_d) * MW'(PASSO);
    pwm_d     = liga && (MW'(cnt_d) < largura_d);
    fim_d     = liga && (cnt_d == CNT_ULT);
  end

  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) begin
      cnt_q      <= '0;
      rodando_q  <= 1'b0;
      pendente_q <= '0;
      ativo_q    <= '0;
      pwm_q      <= 1'b0;
      fim_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      rodando_q  <= rodando_d;
      pendente_q <= pendente_d;
      ativo_q    <= ativo_d;
      pwm_q      <= pwm_d;
      fim_q      <= fim_d;
    end
  end

  assign pwm           = pwm_q;
  assign fim_periodo   = fim_q;
  assign posicao_atual = ativo_q;

endmodule

// File: doc/servo_pwm.md
Name: servo_pwm

Overview:
- Downstream stage of the triangle position counter in the servo path.
- Converts the 3-bit position value into a periodic servo PWM pulse, with pulse width = LARGURA_MIN + posicao*PASSO clock cycles per PERIODO-cycle frame.
- New positions are captured on a load strobe and applied only at frame boundaries, so pulses are never truncated or glitched.
- Emits a one-cycle end-of-frame pulse that drives the upstream counter's conta input.

Parameters:
PERIODO, 1000000, frame length in clock cycles (20 ms at 50 MHz)
LARGURA_MIN, 50000, pulse width for position 0 in cycles (1 ms)
PASSO, 7143, extra pulse cycles per position step
NPOS, 3, width of posicao
POS_MAX, 7, highest legal position (used only with SERVO_LIMITE_EN)

Ports:
clock  input  1  system clock, all logic on rising edge
zera_as_n  input  1  asynchronous active-low reset
liga  input  1  enable; 0 = frame counter held, output low
carrega  input  1  load strobe; sample posicao this cycle
posicao  input  NPOS  requested servo position
pwm  output  1  servo control pulse, registered
fim_periodo  output  1  one-cycle pulse on last cycle of each frame, registered
posicao_atual  output  NPOS  position currently driving pwm

Behaviour:
- Reset (zera_as_n=0, takes effect immediately, independent of clock): frame counter=0, pending=0, active=0, active width=LARGURA_MIN, pwm=0, fim_periodo=0, posicao_atual=0. Reset during a pulse forces pwm low at once. After release, the first frame starts at counter 0.
- Frame counter: ceil(log2(PERIODO)) bits, counts 0..PERIODO-1 while liga=1, then wraps to 0.
- pwm: 1 for exactly the active width of consecutive cycles, starting in the cycle where the counter is 0. It is 0 for the rest of the frame.
- Saturation: if the computed width is >= PERIODO, pwm stays 1 for the whole frame.
- Width arithmetic: computed at full width, LARGURA_MIN + pos*PASSO, with no truncation. The counter and width registers must hold the largest width without overflow.
- fim_periodo: 1 in the cycle where the counter is PERIODO-1 and liga=1; otherwise 0.
- Loading: carrega=1 writes posicao into the pending register. Multiple loads within one frame: the last one wins.
- Frame boundary (counter=PERIODO-1, liga=1): active <= pending. posicao_atual and the width change in the first cycle of the next frame.
- Simultaneous carrega at the boundary: the new posicao bypasses pending and becomes active for the next frame.
- liga=0:
  - Counter is forced to 0; pwm=0 and fim_periodo=0 from the next cycle.
  - active tracks pending continuously, so a loaded value takes effect in the first frame after liga returns to 1.
  - carrega is still honoured.
- liga 0->1: a full new frame starts with counter=0, and pwm rises in that cycle.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: SERVO_LIMITE_EN.
- When defined: posicao values above POS_MAX are clamped to POS_MAX on capture, both into pending and on the bypass path. posicao_atual never exceeds POS_MAX.
- When undefined: no clamp logic is present, and POS_MAX has no effect.

Test Plan:
(All scenarios use PERIODO=20, LARGURA_MIN=4, PASSO=2, NPOS=3, POS_MAX=5.)
1. Reset, then liga=1, no loads -> pwm high for 4 cycles of every 20 (counter 0..3). fim_periodo pulses every 20 cycles at counter 19. posicao_atual=0.
2. carrega=1, posicao=3 at counter 7 -> current frame stays width 4. Next frame pwm width is 10 (counter 0..9). posicao_atual becomes 3 at the next frame's counter 0.
3. carrega=1, posicao=7 at counter 19 -> next frame width 18 without the macro. With SERVO_LIMITE_EN, width 14 and posicao_atual=5.
4. Loads of 2 at counter 3 and 6 at counter 12 in the same frame -> next frame width 16, posicao_atual=6.
5. liga=0 at counter 2 while pwm is high -> pwm=0 and counter 0 on the next cycle, no fim_periodo. Load 1, then liga=1 -> immediate new frame of width 6.
6. zera_as_n=0 asserted mid-pulse with posicao_atual=4 -> pwm, fim_periodo and posicao_atual are 0 without waiting for a clock edge. After release, width is 4.
